// File: rtl/bus_rr_arbiter_if.sv
// Bus-side signal bundle for bus_rr_arbiter: source FIFO heads, destination
// full flags and the arbiter's pop/push/bus outputs.
interface bus_rr_arbiter_if #(
    parameter int num_ntrfs = 4,
    parameter int pckg_sz   = 16
);
    logic [num_ntrfs-1:0]         pndng;
    logic [num_ntrfs*pckg_sz-1:0] data_in;
    logic [num_ntrfs-1:0]         dst_full;
    logic [num_ntrfs-1:0]         pop;
    logic [num_ntrfs-1:0]         push;
    logic [pckg_sz-1:0]           bus_data;
    logic [3:0]                   grant_id;
    logic                         busy;
    logic [7:0]                   drop_cnt;

    modport master (
        input  pndng, data_in, dst_full,
        output pop, push, bus_data, grant_id, busy, drop_cnt
    );

    modport slave (
        output pndng, data_in, dst_full,
        input  pop, push, bus_data, grant_id, busy, drop_cnt
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin router bus arbiter: grant, pop, decode header, push to destination(s).
// Optional SEND backpressure timeout is built only when ARB_TIMEOUT_EN is defined.
module bus_rr_arbiter #(
    parameter int         num_ntrfs = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         timeout   = 64
) (
    input logic              clk,
    input logic              reset,
    bus_rr_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

    state_t               state_q, state_d;
    logic [3:0]           rr_ptr_q, rr_ptr_d;
    logic [3:0]           grant_q, grant_d;
    logic [pckg_sz-1:0]   data_q, data_d;
    logic [7:0]           drop_q, drop_d;
`ifdef ARB_TIMEOUT_EN
    logic [15:0]          wait_q, wait_d;
`endif

    logic [num_ntrfs-1:0] grant_oh;
    logic [num_ntrfs-1:0] target;
    logic [7:0]           dst;
    logic                 is_bcast;
    logic                 dst_ok;
    logic                 blocked;
    logic                 found;
    logic [3:0]           next_src;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Search starts just past the last served source so every requester gets a turn.
    always_comb begin : rr_search
        int idx;
        idx      = 0;
        found    = 1'b0;
        next_src = rr_ptr_q;
        for (int k = 1; k <= num_ntrfs; k++) begin
            idx = (int'(rr_ptr_q) + k) % num_ntrfs;
            if (!found && bus.pndng[idx]) begin
                found    = 1'b1;
                next_src = 4'(idx);
            end
        end
    end

    always_comb begin
        dst      = data_q[pckg_sz-1 -: 8];
        is_bcast = (dst == broadcast);
        dst_ok   = is_bcast || ((int'(dst) < num_ntrfs) && (dst != {4'b0, grant_q}));
        for (int i = 0; i < num_ntrfs; i++) begin
            grant_oh[i] = (grant_q == 4'(i));
            target[i]   = is_bcast ? (grant_q != 4'(i)) : (dst == 8'(i));
        end
        blocked = |(target & bus.dst_full);
    end

    // Broadcast is all-or-nothing: any full target blocks the whole push.
    assign bus.push     = (state_q == SEND && dst_ok && !blocked) ? target : '0;
    assign bus.pop      = (state_q == GRANT) ? grant_oh : '0;
    assign bus.bus_data = data_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.drop_cnt = drop_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        drop_d   = drop_q;
`ifdef ARB_TIMEOUT_EN
        wait_d   = wait_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = next_src;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                data_d  = bus.data_in[int'(grant_q)*pckg_sz +: pckg_sz];
                state_d = SEND;
`ifdef ARB_TIMEOUT_EN
                wait_d  = 16'd0;
`endif
            end
            SEND: begin
                if (!dst_ok) begin
                    drop_d   = sat_inc(drop_q);
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end else if (!blocked) begin
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_q >= 16'(timeout - 1)) begin
                    drop_d   = sat_inc(drop_q);
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // rr_ptr resets to the last terminal so terminal 0 is searched first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 4'(num_ntrfs - 1);
            grant_q  <= 4'd0;
            data_q   <= '0;
            drop_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wait_q <= 16'd0;
        else        wait_q <= wait_d;
    end
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: vector table plus hand-written
// backpressure, reset, round-robin and (with ARB_TIMEOUT_EN) timeout sequences.
module tb_bus_rr_arbiter;
    localparam int N = 4;
    localparam int W = 16;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bus_rr_arbiter_if #(.num_ntrfs(N), .pckg_sz(W)) bus ();

    bus_rr_arbiter #(
        .num_ntrfs(N), .pckg_sz(W), .broadcast(8'hFF), .timeout(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int          src;
        logic [15:0] data;
        logic [3:0]  exp_push;
    } vec_t;

    typedef struct {
        logic [3:0]  push;
        logic [15:0] data;
    } sb_t;

    vec_t vecs [9];
    sb_t  sb_q [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put_data(input int src, input logic [15:0] d);
        bus.data_in[src*W +: W] = d;
    endtask

    // Scoreboard: every observed push must match the oldest expected delivery.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (bus.push != '0) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_push", 32'(bus.push), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_push", 32'(bus.push), 32'(e.push));
                    check("sb_data", 32'(bus.bus_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_drop;
        int s;
        logic [3:0] oh;

        vecs[0] = '{0, 16'h02AB, 4'b0100};
        vecs[1] = '{1, 16'h0300, 4'b1000};
        vecs[2] = '{3, 16'h0000, 4'b0001};
        vecs[3] = '{2, 16'h0111, 4'b0010};
        vecs[4] = '{1, 16'hFF55, 4'b1101};
        vecs[5] = '{0, 16'hFF00, 4'b1110};
        vecs[6] = '{3, 16'hFFAA, 4'b0111};
        vecs[7] = '{2, 16'h0711, 4'b0000};
        vecs[8] = '{2, 16'h0233, 4'b0000};

        bus.pndng    = '0;
        bus.data_in  = '0;
        bus.dst_full = '0;

        #12;
        check("rst_pop", 32'(bus.pop), 32'h0);
        check("rst_push", 32'(bus.push), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_grant", 32'(bus.grant_id), 32'h0);
        check("rst_bus_data", 32'(bus.bus_data), 32'h0);
        check("rst_drop", 32'(bus.drop_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Single-source vectors: pop in cycle 1, push (or drop) in cycle 2.
        exp_drop = 0;
        for (int v = 0; v < 9; v++) begin
            @(posedge clk); #1;
            put_data(vecs[v].src, vecs[v].data);
            bus.pndng = 4'(1 << vecs[v].src);
            if (vecs[v].exp_push != '0) sb_q.push_back('{vecs[v].exp_push, vecs[v].data});
            @(posedge clk); @(negedge clk);
            check($sformatf("v%0d_pop", v), 32'(bus.pop), 32'(1 << vecs[v].src));
            check($sformatf("v%0d_grant", v), 32'(bus.grant_id), 32'(vecs[v].src));
            check($sformatf("v%0d_busy", v), 32'(bus.busy), 32'h1);
            @(posedge clk); #1;
            bus.pndng = '0;
            @(negedge clk);
            check($sformatf("v%0d_push", v), 32'(bus.push), 32'(vecs[v].exp_push));
            check($sformatf("v%0d_bus_data", v), 32'(bus.bus_data), 32'(vecs[v].data));
            if (vecs[v].exp_push == '0) exp_drop++;
            @(posedge clk); @(negedge clk);
            check($sformatf("v%0d_idle", v), 32'(bus.busy), 32'h0);
            check($sformatf("v%0d_drop", v), 32'(bus.drop_cnt), 32'(exp_drop));
        end

        // Broadcast held off by dst_full[3] for 5 cycles, then delivered whole.
        @(posedge clk); #1;
        put_data(1, 16'hFF55);
        bus.pndng    = 4'b0010;
        bus.dst_full = 4'b1000;
        sb_q.push_back('{4'b1101, 16'hFF55});
        @(posedge clk); @(negedge clk);
        check("bp_pop", 32'(bus.pop), 32'h2);
        @(posedge clk); #1;
        bus.pndng = '0;
        @(negedge clk);
        check("bp_hold0", 32'(bus.push), 32'h0);
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("bp_hold%0d", c), 32'(bus.push), 32'h0);
            check($sformatf("bp_busy%0d", c), 32'(bus.busy), 32'h1);
        end
        @(posedge clk); #1;
        bus.dst_full = '0;
        @(negedge clk);
        check("bp_release_push", 32'(bus.push), 32'hD);
        @(posedge clk); @(negedge clk);
        check("bp_idle", 32'(bus.busy), 32'h0);

        // Reset asserted while SEND waits on a full destination.
        @(posedge clk); #1;
        put_data(0, 16'h0200);
        bus.pndng    = 4'b0001;
        bus.dst_full = 4'b0100;
        @(posedge clk); @(negedge clk);
        check("rs_pop", 32'(bus.pop), 32'h1);
        @(posedge clk); #1;
        bus.pndng = '0;
        @(negedge clk);
        check("rs_send_hold", 32'(bus.push), 32'h0);
        check("rs_send_busy", 32'(bus.busy), 32'h1);
        check("rs_drop_before", 32'(bus.drop_cnt), 32'h2);
        #2 reset = 1'b0;
        #1;
        check("rs_push", 32'(bus.push), 32'h0);
        check("rs_pop0", 32'(bus.pop), 32'h0);
        check("rs_busy", 32'(bus.busy), 32'h0);
        check("rs_bus_data", 32'(bus.bus_data), 32'h0);
        check("rs_grant", 32'(bus.grant_id), 32'h0);
        check("rs_drop", 32'(bus.drop_cnt), 32'h0);
        bus.dst_full = '0;
        @(negedge clk);
        reset = 1'b1;

        // All sources pending from reset: grants 0,1,2,3,0 every 3 cycles.
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) put_data(i, {8'((i + 1) % N), 8'(8'hA0 + i)});
        bus.pndng = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            s  = k % N;
            oh = 4'(1 << ((s + 1) % N));
            sb_q.push_back('{oh, {8'((s + 1) % N), 8'(8'hA0 + s)}});
            @(posedge clk); @(negedge clk);
            check($sformatf("rr%0d_pop", k), 32'(bus.pop), 32'(1 << s));
            check($sformatf("rr%0d_grant", k), 32'(bus.grant_id), 32'(s));
            @(posedge clk); @(negedge clk);
            check($sformatf("rr%0d_push", k), 32'(bus.push), 32'(oh));
            @(posedge clk); #1;
            if (k == 4) bus.pndng = '0;
            @(negedge clk);
            check($sformatf("rr%0d_idle", k), 32'(bus.busy), 32'h0);
        end

`ifdef ARB_TIMEOUT_EN
        // Blocked unicast is dropped after 8 SEND cycles.
        @(posedge clk); #1;
        put_data(1, 16'h0000);
        bus.pndng    = 4'b0010;
        bus.dst_full = 4'b0001;
        @(posedge clk); @(negedge clk);
        check("to_pop", 32'(bus.pop), 32'h2);
        @(posedge clk); #1;
        bus.pndng = '0;
        @(negedge clk);
        check("to_hold0", 32'(bus.push), 32'h0);
        for (int c = 1; c < 8; c++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("to_hold%0d", c), 32'(bus.push), 32'h0);
            check($sformatf("to_busy%0d", c), 32'(bus.busy), 32'h1);
        end
        @(posedge clk); @(negedge clk);
        check("to_idle", 32'(bus.busy), 32'h0);
        check("to_drop", 32'(bus.drop_cnt), 32'h1);
        bus.dst_full = '0;
`endif

        @(posedge clk); @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
